// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and default parameters for the SPI transaction sequencer
package spi_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } seq_state_e;

  localparam int unsigned DEF_FIFO_DEPTH     = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32;

endpackage

// File: rtl/spi_seq_fifo.sv
// rtl/spi_seq_fifo.sv - synchronous byte FIFO with occupancy count and flush
module spi_seq_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  byte_t                  data_i,
  input  logic                   pop_i,
  output byte_t                  data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A pop that has data frees its slot in the same cycle, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// rtl/spi_txn_sequencer.sv - sequences TX FIFO bytes to an SPI master and collects RX bytes
// Optional per-byte done timeout enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_txn_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic                        start,
  input  logic [$clog2(FIFO_DEPTH):0] len,
  output logic                        busy,
  output logic                        txn_done,
  output logic                        err,
  output logic                        rx_ovf,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [7:0]                  m_tx_data,
  output logic                        m_tx_valid,
  input  logic                        m_tx_done,
  input  logic [7:0]                  m_rx_data,
  input  logic                        m_rx_valid
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  seq_state_e    state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  byte_t         tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic [LW-1:0] tx_count;
  logic [LW-1:0] rx_count;
  byte_t         tx_head;
  byte_t         rx_head;
  logic          tx_pop;
  logic          tx_flush;
  logic          rx_full;
  logic          rx_drop;
  logic          start_ok;
  logic          tmo_hit;

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (tx_flush),
    .push_i  (wr_valid),
    .data_i  (wr_data),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .count_o (tx_count)
  );

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (m_rx_valid),
    .data_i  (m_rx_data),
    .pop_i   (rd_ready),
    .data_o  (rx_head),
    .count_o (rx_count)
  );

  assign wr_ready   = (tx_count != LW'(FIFO_DEPTH));
  assign rx_full    = (rx_count == LW'(FIFO_DEPTH));
  assign rd_valid   = (rx_count != '0);
  assign rd_data    = rd_valid ? rx_head : '0;
  assign rx_drop    = m_rx_valid && rx_full && !rd_ready;
  assign start_ok   = (len != '0) && (len <= tx_count);
  assign busy       = (state_q != IDLE);
  assign txn_done   = done_q;
  assign err        = err_q;
  assign rx_ovf     = ovf_q;
  assign m_tx_data  = tx_data_q;
  assign m_tx_valid = tx_valid_q;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] tmo_q, tmo_d;

  // Counts cycles spent in WAIT_DONE for the current byte; restarts at zero for every byte.
  assign tmo_hit = (state_q == WAIT_DONE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_DONE && !m_tx_done && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ovf_d      = ovf_q;
    tx_pop     = 1'b0;
    tx_flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            rem_d   = len;
            ovf_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        tx_pop     = 1'b1;
        tx_data_d  = tx_head;
        tx_valid_d = 1'b1;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (m_tx_done) begin
          rem_d   = rem_q - 1'b1;
          state_d = GAP;
        end else if (tmo_hit) begin
          err_d    = 1'b1;
          tx_flush = 1'b1;
          rem_d    = '0;
          state_d  = IDLE;
        end
      end
      GAP: begin
        if (rem_q != '0) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A dropped RX byte wins over the clear from a same-cycle start.
    if (rx_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb/tb_spi_txn_sequencer.sv - directed self-checking bench for spi_txn_sequencer
module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       start;
  logic [3:0] len;
  logic       busy;
  logic       txn_done;
  logic       err;
  logic       rx_ovf;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] m_tx_data;
  logic       m_tx_valid;
  logic       m_tx_done;
  logic [7:0] m_rx_data;
  logic       m_rx_valid;

  logic       mst_done;
  logic       mst_rx_valid;
  logic [7:0] mst_rx_data;
  logic       inj_valid;
  logic [7:0] inj_data;
  logic       master_en;
  int         n_issue;
  logic [7:0] issue_log [16];

  int checks = 0;
  int errors = 0;

  assign m_tx_done  = mst_done;
  assign m_rx_valid = mst_rx_valid | inj_valid;
  assign m_rx_data  = inj_valid ? inj_data : mst_rx_data;

  always #5 clk = ~clk;

  spi_txn_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .txn_done   (txn_done),
    .err        (err),
    .rx_ovf     (rx_ovf),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .m_tx_data  (m_tx_data),
    .m_tx_valid (m_tx_valid),
    .m_tx_done  (m_tx_done),
    .m_rx_data  (m_rx_data),
    .m_rx_valid (m_rx_valid)
  );

  // Loopback SPI master: echoes each requested byte back as MISO two cycles later.
  initial begin
    mst_done     = 1'b0;
    mst_rx_valid = 1'b0;
    mst_rx_data  = 8'h00;
    n_issue      = 0;
    forever begin
      @(posedge clk);
      #1;
      mst_done     = 1'b0;
      mst_rx_valid = 1'b0;
      if (m_tx_valid && !rst) begin
        if (n_issue < 16) issue_log[n_issue] = m_tx_data;
        n_issue++;
        if (master_en) begin
          repeat (2) @(posedge clk);
          #1;
          if (!rst) begin
            mst_done     = 1'b1;
            mst_rx_valid = 1'b1;
            mst_rx_data  = m_tx_data;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wr_ready"},   wr_ready,   1);
    check({tag, " busy"},       busy,       0);
    check({tag, " txn_done"},   txn_done,   0);
    check({tag, " err"},        err,        0);
    check({tag, " rx_ovf"},     rx_ovf,     0);
    check({tag, " rd_valid"},   rd_valid,   0);
    check({tag, " rd_data"},    rd_data,    0);
    check({tag, " m_tx_valid"}, m_tx_valid, 0);
    check({tag, " m_tx_data"},  m_tx_data,  0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic start_txn(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pop_byte();
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int dones);
    bit ok;
    ok    = 1'b0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (txn_done) dones++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " reached idle"}, 32'(ok), 1);
  endtask

  initial begin
    int dones;
    int base;
    int hit;
    bit seen;

    rst       = 1'b1;
    wr_data   = 8'h00;
    wr_valid  = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    rd_ready  = 1'b0;
    inj_valid = 1'b0;
    inj_data  = 8'h00;
    master_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Two-byte loopback transaction
    push_byte(8'hA5);
    push_byte(8'h3C);
    base = n_issue;
    start_txn(4'd2);
    check("t1 busy", busy, 1);
    wait_idle("t1", dones);
    check("t1 txn_done count", dones, 1);
    check("t1 issue count", n_issue - base, 2);
    check("t1 mosi0", issue_log[base], 8'hA5);
    check("t1 mosi1", issue_log[base + 1], 8'h3C);
    check("t1 m_tx_data hold", m_tx_data, 8'h3C);
    check("t1 rd_valid", rd_valid, 1);
    check("t1 rx0", rd_data, 8'hA5);
    pop_byte();
    check("t1 rx1", rd_data, 8'h3C);
    pop_byte();
    check("t1 rx empty", rd_valid, 0);

    // Rejected starts: len beyond occupancy, then len zero
    push_byte(8'h11);
    start_txn(4'd3);
    check("t2 err pulse", err, 1);
    check("t2 busy", busy, 0);
    @(posedge clk);
    #1;
    check("t2 err one cycle", err, 0);
    check("t2 tx count", dut.u_tx_fifo.count_o, 1);
    start_txn(4'd0);
    check("t2 len0 err", err, 1);
    check("t2 len0 busy", busy, 0);

    // RX overflow: prefill RX full, then loop one byte back
    for (int i = 0; i < 8; i++) begin
      inj_valid = 1'b1;
      inj_data  = 8'h80 + 8'(i);
      @(posedge clk);
      #1;
    end
    inj_valid = 1'b0;
    check("t3 rx prefill count", dut.u_rx_fifo.count_o, 8);
    start_txn(4'd1);
    wait_idle("t3a", dones);
    check("t3 done", dones, 1);
    check("t3 rx_ovf set", rx_ovf, 1);
    check("t3 rx count", dut.u_rx_fifo.count_o, 8);
    check("t3 rx head", rd_data, 8'h80);
    push_byte(8'h22);
    start_txn(4'd1);
    check("t3 rx_ovf cleared by start", rx_ovf, 0);
    wait_idle("t3b", dones);
    check("t3 rx_ovf set again", rx_ovf, 1);
    rd_ready  = 1'b1;
    inj_valid = 1'b1;
    inj_data  = 8'h99;
    @(posedge clk);
    #1;
    rd_ready  = 1'b0;
    inj_valid = 1'b0;
    check("t3 full push+pop count", dut.u_rx_fifo.count_o, 8);
    check("t3 full push+pop head", rd_data, 8'h81);
    for (int i = 0; i < 7; i++) pop_byte();
    check("t3 pushed tail", rd_data, 8'h99);
    pop_byte();
    check("t3 rx drained", rd_valid, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Master never reports done: timeout flushes TX and returns to IDLE
    master_en = 1'b0;
    push_byte(8'h55);
    push_byte(8'h66);
    start_txn(4'd1);
    hit  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (txn_done) seen = 1'b1;
      if (err) begin
        hit = i;
        break;
      end
    end
    check("t4 err latency", hit, 33);
    check("t4 busy", busy, 0);
    check("t4 tx flushed", dut.u_tx_fifo.count_o, 0);
    check("t4 no txn_done", 32'(seen), 0);
    master_en = 1'b1;
    @(posedge clk);
    #1;
`endif

    // Reset in the middle of a four-byte transaction
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    base = n_issue;
    start_txn(4'd4);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (n_issue >= base + 2) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5 second byte issued", 32'(seen), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5 in reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5 tx empty", dut.u_tx_fifo.count_o, 0);
    check("t5 rx empty", dut.u_rx_fifo.count_o, 0);
    push_byte(8'h77);
    start_txn(4'd1);
    wait_idle("t5", dones);
    check("t5 done", dones, 1);
    check("t5 rd_valid", rd_valid, 1);
    check("t5 rx data", rd_data, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_txn_sequencer.md
SPI_TXN_SEQUENCER -- requirements
Module: spi_txn_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, TX/RX FIFO entries each; power of two, 2..64.
REQ-002 Parameter: TIMEOUT_CYCLES, default 32, cycles allowed per byte for the master to report done.
REQ-003 clk  in  1  single clock; all logic posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wr_data  in  8  host byte to TX FIFO.
REQ-006 wr_valid/wr_ready  in/out  1  TX FIFO push handshake; push when both high.
REQ-007 start  in  1  one-cycle pulse; begin transaction.
REQ-008 len  in  $clog2(FIFO_DEPTH)+1  byte count, sampled with start.
REQ-009 busy  out  1  transaction in progress.
REQ-010 txn_done  out  1  one-cycle pulse at transaction end.
REQ-011 err  out  1  one-cycle pulse: rejected start or timeout.
REQ-012 rx_ovf  out  1  sticky; RX byte dropped.
REQ-013 rd_data  out  8  RX FIFO head.
REQ-014 rd_valid/rd_ready  out/in  1  RX FIFO pop handshake.
REQ-015 m_tx_data  out  8  byte to SPI master.
REQ-016 m_tx_valid  out  1  byte request to SPI master.
REQ-017 m_tx_done  in  1  master finished shifting byte.
REQ-018 m_rx_data  in  8  byte received by master.
REQ-019 m_rx_valid  in  1  m_rx_data valid, one cycle.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT_DONE, GAP; IDLE on reset.
REQ-021 IDLE: start with 1<=len<=TX occupancy -> latch len into remaining counter, clear rx_ovf, go ISSUE; otherwise start ignored and err pulses next cycle.
REQ-022 ISSUE: pop TX head into m_tx_data register, assert m_tx_valid for exactly one cycle, go WAIT_DONE.
REQ-023 m_tx_data holds stable from ISSUE until next ISSUE.
REQ-024 WAIT_DONE: on m_tx_done, decrement remaining, go GAP.
REQ-025 GAP: one idle cycle (master returns to idle); remaining!=0 -> ISSUE, else IDLE with txn_done pulse.
REQ-026 m_rx_valid in any state pushes m_rx_data into RX FIFO; if full (and no same-cycle pop), byte dropped, rx_ovf set.
REQ-027 Simultaneous push/pop on full or empty FIFO: both succeed when the pop has data; occupancy unchanged.
REQ-028 wr_ready = TX not full; host pushes allowed during a transaction.
REQ-029 busy = state != IDLE; start while busy ignored, no err.
REQ-030 start with len=0 -> err, no state change.

Reset
REQ-031 rst asserted at any time: state IDLE, both FIFOs empty, remaining=0, counters 0, in-flight byte abandoned.
REQ-032 Reset values: wr_ready=1, busy=0, txn_done=0, err=0, rx_ovf=0, rd_valid=0, rd_data=0, m_tx_valid=0, m_tx_data=0.

Configuration
REQ-033 Macro SPI_SEQ_TIMEOUT_EN defined: per-byte counter runs in WAIT_DONE; reaching TIMEOUT_CYCLES -> err pulse, TX FIFO flushed, IDLE, no txn_done.
REQ-034 Macro undefined: no counter; WAIT_DONE waits indefinitely.

Structure
REQ-035 Package spi_pkg: byte_t (8-bit), seq_state_e enum, default FIFO_DEPTH and TIMEOUT_CYCLES constants.
REQ-036 Sub-module spi_seq_fifo (sync FIFO, width 8, depth param, count output, flush input), instantiated for TX and RX.

Verification
REQ-037 Push 0xA5,0x3C; start len=2; model master loops MOSI to MISO -> two m_tx_valid pulses, data 0xA5 then 0x3C, txn_done once, RX reads 0xA5,0x3C.
REQ-038 TX holds 1 byte; start len=3 -> err pulse next cycle, busy stays 0, TX occupancy stays 1.
REQ-039 RX pre-filled to 8 with rd_ready=0; run 1-byte transaction -> rx_ovf=1, RX count 8; next start clears rx_ovf.
REQ-040 SPI_SEQ_TIMEOUT_EN defined, master never asserts m_tx_done -> err 32 cycles after entering WAIT_DONE, TX empty, busy=0.
REQ-041 rst pulse mid-transaction after byte 1 of 4 -> all outputs at reset values, next start with len=1 after refill completes normally.
